disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit scan step (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port value  input  8  ALU result to display.
REQ-005 SHALL have port sgn  input  1  1 = value is two's complement, 0 = unsigned.
REQ-006 SHALL have port ovf  input  1  ALU overflow flag; display "overload" instead of value.
REQ-007 SHALL have port load  input  1  single-cycle request to capture value/sgn/ovf.
REQ-008 SHALL have port busy  output  1  high while a capture is being converted.
REQ-009 SHALL have port nib  output  4  digit code for the seven-segment decoder (0-9 digits, A minus, B overload, F blank).
REQ-010 SHALL have port an  output  4  active-low one-hot digit enable, an[0] = rightmost digit.

Function
REQ-011 SHALL hold four digit registers d3..d0 (d3 leftmost), displayed only after a completed conversion.
REQ-012 SHALL implement FSM IDLE -> CONV -> COMMIT -> IDLE.
REQ-013 SHALL, in IDLE with load=1 at edge N, capture value, sgn and ovf, enter CONV, and assert busy from edge N onward.
REQ-014 SHALL ignore load while in CONV or COMMIT (no queuing, no restart).
REQ-015 SHALL compute magnitude = -value when sgn=1 and value[7]=1, else value, as 8-bit unsigned (0x80 signed -> 128).
REQ-016 SHALL convert magnitude to 3 BCD digits by sequential shift-add-3, one bit per cycle, exactly 8 CONV cycles (edges N+1..N+8).
REQ-017 SHALL enter COMMIT at edge N+8, write d3..d0 at edge N+9, return to IDLE and drop busy at edge N+9.
REQ-018 SHALL set d3 = A when sgn=1 and captured value[7]=1, else F.
REQ-019 SHALL blank leading zeros: d2 = F if hundreds=0; d1 = F if hundreds=0 and tens=0; d0 never blanked.
REQ-020 SHALL, when captured ovf=1, write d3..d0 = F,F,F,B regardless of value and sign (conversion still takes full latency).
REQ-021 SHALL run a prescaler counting 0..SCAN_DIV-1 continuously, independent of FSM state, issuing a one-cycle tick at count SCAN_DIV-1 and wrapping to 0.
REQ-022 SHALL, on tick, advance digit index 0->1->2->3->0 and register an = ~(1<<index) and nib = d[index] on the same edge.
REQ-023 SHALL update nib on the next tick after COMMIT (display content changes only at scan steps; an and nib never mismatch).
REQ-024 SHALL keep exactly one an bit low at all times after reset.

Reset
REQ-025 SHALL, on rst_n=0, immediately set state IDLE, busy=0, d3..d0=F, prescaler=0, index=0, an=4'b1110, nib=4'hF.
REQ-026 SHALL discard any in-progress conversion on reset; display stays blank until the next completed load.
REQ-027 SHALL leave reset synchronously to clk; first load accepted on the first edge with rst_n=1.

Verification (bench uses SCAN_DIV=4)
REQ-028 SHALL verify reset: rst_n low mid-CONV -> busy=0, an=1110, nib=F at once; no digit update follows.
REQ-029 SHALL verify value=123, sgn=0, load at edge N -> busy high N..N+8, low after N+9; scan yields nib 3,2,1,F on an 1110,1101,1011,0111.
REQ-030 SHALL verify value=0xFB, sgn=1 -> d3..d0 = A,F,F,5; value=0x80, sgn=1 -> A,1,2,8; value=0x80, sgn=0 -> F,1,2,8.
REQ-031 SHALL verify value=0, sgn=0 -> F,F,F,0; value=0x0A -> F,F,1,0.
REQ-032 SHALL verify ovf=1, value=0x55 -> F,F,F,B.
REQ-033 SHALL verify load=1 held 12 cycles with value changing -> only value at first edge is displayed; a second conversion starts at edge N+10.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: captures an 8-bit ALU result,
// converts it to signed/blanked BCD with a sequential double-dabble and multiplexes the digits.
module disp_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] value,
   input  logic       sgn,
   input  logic       ovf,
   input  logic       load,
   output logic       busy,
   output logic [3:0] nib,
   output logic [3:0] an
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  bitCnt_q, bitCnt_d;
   logic        neg_q, neg_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic [15:0] dig_q, dig_d;

   logic [CW-1:0] scanCnt_q, scanCnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [3:0]    nib_q, nib_d;

   logic          tick;
   logic [1:0]    idxNext;
   logic [11:0]   bcdAdj;
   logic [3:0]    hund, tens, ones;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Conversion FSM: capture magnitude, eight shift-add-3 steps, then write the digit registers.
   always_comb begin
      state_d  = state_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      bitCnt_d = bitCnt_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      dig_d    = dig_q;
      bcdAdj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      hund     = bcd_q[11:8];
      tens     = bcd_q[7:4];
      ones     = bcd_q[3:0];
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d  = CONV;
               busy_d   = 1'b1;
               neg_d    = sgn & value[7];
               ovf_d    = ovf;
               bin_d    = (sgn & value[7]) ? (~value + 8'd1) : value;
               bcd_d    = 12'd0;
               bitCnt_d = 3'd0;
            end
         end
         CONV: begin
            bcd_d    = {bcdAdj[10:0], bin_q[7]};
            bin_d    = {bin_q[6:0], 1'b0};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (ovf_q) begin
               dig_d = 16'hFFFB;
            end else begin
               // Leading zeros blank; the units digit always shows.
               dig_d[15:12] = neg_q ? 4'hA : 4'hF;
               dig_d[11:8]  = (hund == 4'd0) ? 4'hF : hund;
               dig_d[7:4]   = ((hund == 4'd0) && (tens == 4'd0)) ? 4'hF : tens;
               dig_d[3:0]   = ones;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running prescaler and digit multiplexer; an and nib always move together on a tick.
   always_comb begin
      tick      = (scanCnt_q == LAST);
      idxNext   = idx_q + 2'd1;
      scanCnt_d = tick ? '0 : scanCnt_q + CW'(1);
      idx_d     = idx_q;
      an_d      = an_q;
      nib_d     = nib_q;
      if (tick) begin
         idx_d = idxNext;
         an_d  = ~(4'b0001 << idxNext);
         nib_d = dig_q[{idxNext, 2'b00} +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bin_q     <= 8'd0;
         bcd_q     <= 12'd0;
         bitCnt_q  <= 3'd0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         dig_q     <= 16'hFFFF;
         scanCnt_q <= '0;
         idx_q     <= 2'd0;
         an_q      <= 4'b1110;
         nib_q     <= 4'hF;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         bitCnt_q  <= bitCnt_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         dig_q     <= dig_d;
         scanCnt_q <= scanCnt_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         nib_q     <= nib_d;
      end
   end

   assign busy = busy_q;
   assign nib  = nib_q;
   assign an   = an_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized scoreboard bench for disp_scan_ctrl: an arithmetic reference model predicts the
// digits of each accepted load, and a monitor checks busy, the scan rotation and every shown digit.
module tb_disp_scan_ctrl;

   localparam int SCAN_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] value = 8'd0;
   logic       sgn = 1'b0;
   logic       ovf = 1'b0;
   logic       load = 1'b0;
   logic       busy;
   logic [3:0] nib;
   logic [3:0] an;

   int nChecks = 0;
   int nFails  = 0;

   logic [15:0] expQ[$];
   logic [15:0] expDisp  = 16'hFFFF;
   int          busyLeft = 0;
   int          preCnt   = 0;
   int          scanIdx  = 0;
   logic        busyPrev = 1'b0;

   disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .value(value),
      .sgn  (sgn),
      .ovf  (ovf),
      .load (load),
      .busy (busy),
      .nib  (nib),
      .an   (an)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Display digits {d3,d2,d1,d0} computed directly from decimal arithmetic.
   function automatic logic [15:0] refDigits(input logic [7:0] v, input logic s, input logic o);
      int mag, h, t, u;
      logic neg;
      logic [3:0] d3, d2, d1, d0;
      if (o) return 16'hFFFB;
      neg = s && (v >= 8'd128);
      mag = neg ? 256 - int'(v) : int'(v);
      h   = mag / 100;
      t   = (mag / 10) % 10;
      u   = mag % 10;
      d3  = neg ? 4'hA : 4'hF;
      d2  = (h == 0) ? 4'hF : 4'(h);
      d1  = (h == 0 && t == 0) ? 4'hF : 4'(t);
      d0  = 4'(u);
      return {d3, d2, d1, d0};
   endfunction

   // Monitor: model timing of busy and the scan, pop the scoreboard when the DUT finishes a conversion.
   always @(posedge clk) begin
      logic       sRst, sLoad, sSgn, sOvf;
      logic [7:0] sVal;
      logic [3:0] expAn;
      bit         tick;
      sRst  = rst_n;
      sLoad = load;
      sVal  = value;
      sSgn  = sgn;
      sOvf  = ovf;
      #1;
      if (!sRst) begin
         busyLeft = 0;
         preCnt   = 0;
         scanIdx  = 0;
         expDisp  = 16'hFFFF;
         expQ.delete();
         busyPrev = 1'b0;
         checkOutput("reset_busy", {15'd0, busy}, 16'd0);
         checkOutput("reset_an", {12'd0, an}, 16'h000E);
         checkOutput("reset_nib", {12'd0, nib}, 16'h000F);
      end else begin
         if (busyLeft == 0) begin
            if (sLoad) begin
               busyLeft = 9;
               expQ.push_back(refDigits(sVal, sSgn, sOvf));
            end
         end else begin
            busyLeft--;
         end
         tick   = (preCnt == SCAN_DIV - 1);
         preCnt = tick ? 0 : preCnt + 1;
         if (tick) scanIdx = (scanIdx + 1) % 4;
         expAn = ~(4'b0001 << scanIdx);
         checkOutput("busy", {15'd0, busy}, {15'd0, busyLeft > 0});
         checkOutput("an", {12'd0, an}, {12'd0, expAn});
         if (tick) checkOutput("nib", {12'd0, nib}, {12'd0, expDisp[scanIdx*4 +: 4]});
         if (busyPrev && !busy) begin
            if (expQ.size() == 0) begin
               checkOutput("commit_without_load", 16'd1, 16'd0);
            end else begin
               expDisp = expQ.pop_front();
            end
         end
         busyPrev = busy;
      end
   end

   task automatic applyStimulus(input logic [7:0] v, input logic s, input logic o, input int gap);
      @(negedge clk);
      value = v;
      sgn   = s;
      ovf   = o;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      value = 8'($urandom);
      sgn   = 1'($urandom);
      ovf   = 1'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(8'd123, 1'b0, 1'b0, 28);
      applyStimulus(8'hFB, 1'b1, 1'b0, 28);
      applyStimulus(8'h80, 1'b1, 1'b0, 28);
      applyStimulus(8'h80, 1'b0, 1'b0, 28);
      applyStimulus(8'h00, 1'b0, 1'b0, 28);
      applyStimulus(8'h0A, 1'b0, 1'b0, 28);
      applyStimulus(8'h55, 1'b0, 1'b1, 28);
      applyStimulus(8'hFF, 1'b1, 1'b1, 28);

      // Load held high while the operand keeps changing.
      @(negedge clk);
      load = 1'b1;
      for (int i = 0; i < 12; i++) begin
         value = 8'($urandom);
         sgn   = 1'($urandom);
         ovf   = 1'b0;
         @(negedge clk);
      end
      load = 1'b0;
      repeat (30) @(negedge clk);

      // Asynchronous reset in the middle of a conversion.
      applyStimulus(8'd200, 1'b0, 1'b0, 3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("async_rst_an", {12'd0, an}, 16'h000E);
      checkOutput("async_rst_nib", {12'd0, nib}, 16'h000F);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 30));
      end
      repeat (30) @(negedge clk);

      checkOutput("queue_empty", 16'(expQ.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
